// File: rtl/tinycodec_pkg.sv
// Shared constants and types for the coefficient path between the entropy
// decoder and the dequantizer.
package tinycodec_pkg;

    localparam int COEF_W      = 12;
    localparam int BLOCK_COEFS = 64;
    localparam int ZRL_RUN     = 15;
    localparam int CNT_W       = 16;
    localparam int IDX_W       = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_COEFS - 1);

    typedef enum logic [2:0] {
        WAIT_DC = 3'd0,
        WAIT_AC = 3'd1,
        ZEROS   = 3'd2,
        VALUE   = 3'd3,
        FILL    = 3'd4
    } seq_state_t;

    typedef logic signed [COEF_W-1:0] coef_t;

endpackage

// File: rtl/coef_block_sequencer.sv
// Expands (value, run, dc) symbols into one zigzag-ordered coefficient per
// cycle, handling EOB/ZRL, block completion and sticky protocol errors.
module coef_block_sequencer
    import tinycodec_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic signed [COEF_W-1:0] sym_value_in,
    input  logic [4:0]               sym_run_in,
    input  logic                     sym_dc_in,
    input  logic                     sym_valid_in,
    output logic                     sym_ready_out,
    output logic signed [COEF_W-1:0] coef_value_out,
    output logic [IDX_W-1:0]         coef_index_out,
    output logic                     coef_last_out,
    output logic                     coef_valid_out,
    input  logic                     coef_ready_in,
    output logic                     err_out,
    output logic [CNT_W-1:0]         block_count_out
);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4:0]        pend_q, pend_d;
    logic              then_val_q, then_val_d;
    coef_t             val_q, val_d;
    logic              run_q;
    coef_t             out_val_q, out_val_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              adv_s;
    logic              ready_s;
    logic              accept_s;
    logic              is_eob_s;
    logic              is_zrl_s;
    logic              emit_s;
    logic              owe_val_s;
    coef_t             emit_val_s;
    logic [IDX_W-1:0]  emit_idx_s;

    assign adv_s    = !out_valid_q || coef_ready_in;
    assign ready_s  = run_q && adv_s && ((state_q == WAIT_DC) || (state_q == WAIT_AC));
    assign accept_s = sym_valid_in && ready_s;
    assign is_eob_s = (sym_value_in == {COEF_W{1'b0}}) && (sym_run_in == 5'd0);
    assign is_zrl_s = (sym_value_in == {COEF_W{1'b0}}) && (sym_run_in == 5'(ZRL_RUN));

    // Next-state: choose what (if anything) enters the output register this cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        then_val_d  = then_val_q;
        val_d       = val_q;
        err_d       = err_q;
        emit_s      = 1'b0;
        emit_val_s  = {COEF_W{1'b0}};
        emit_idx_s  = idx_q;
        owe_val_s   = 1'b0;

        case (state_q)
            WAIT_DC: begin
                if (accept_s && sym_dc_in) begin
                    emit_s     = 1'b1;
                    emit_val_s = sym_value_in;
                    emit_idx_s = {IDX_W{1'b0}};
                    state_d    = WAIT_AC;
                end else if (accept_s) begin
                    err_d = 1'b1;
                end else begin
                    state_d = WAIT_DC;
                end
            end
            WAIT_AC: begin
                if (accept_s) begin
                    val_d  = sym_value_in;
                    emit_s = 1'b1;
                    if (sym_dc_in) begin
                        // Restart: the interrupted block is neither filled nor counted.
                        err_d      = 1'b1;
                        emit_val_s = sym_value_in;
                        emit_idx_s = {IDX_W{1'b0}};
                        state_d    = WAIT_AC;
                    end else if (is_eob_s) begin
                        state_d = FILL;
                    end else if (is_zrl_s) begin
                        pend_d     = 5'(ZRL_RUN);
                        then_val_d = 1'b0;
                        state_d    = ZEROS;
                    end else if (sym_run_in == 5'd0) begin
                        emit_val_s = sym_value_in;
                        state_d    = WAIT_AC;
                    end else begin
                        pend_d     = sym_run_in - 5'd1;
                        then_val_d = 1'b1;
                        owe_val_s  = 1'b1;
                        state_d    = (sym_run_in == 5'd1) ? VALUE : ZEROS;
                    end
                end else begin
                    state_d = WAIT_AC;
                end
            end
            ZEROS: begin
                if (adv_s) begin
                    emit_s    = 1'b1;
                    pend_d    = pend_q - 5'd1;
                    owe_val_s = then_val_q;
                    if (pend_q == 5'd1) begin
                        state_d = then_val_q ? VALUE : WAIT_AC;
                    end else begin
                        state_d = ZEROS;
                    end
                end else begin
                    state_d = ZEROS;
                end
            end
            VALUE: begin
                if (adv_s) begin
                    emit_s     = 1'b1;
                    emit_val_s = val_q;
                    state_d    = WAIT_AC;
                end else begin
                    state_d = VALUE;
                end
            end
            FILL: begin
                if (adv_s) begin
                    emit_s = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = WAIT_DC;
            end
        endcase

        out_val_d   = out_val_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !coef_ready_in;
        if (emit_s) begin
            out_valid_d = 1'b1;
            out_val_d   = emit_val_s;
            out_idx_d   = emit_idx_s;
            out_last_d  = (emit_idx_s == LAST_IDX);
            // Index 63 closes the block no matter what emissions remain pending.
            if (emit_idx_s == LAST_IDX) begin
                state_d = WAIT_DC;
                idx_d   = {IDX_W{1'b0}};
                err_d   = err_d | owe_val_s;
            end else begin
                idx_d = emit_idx_s + 6'd1;
            end
        end else begin
            idx_d = idx_d;
        end

        if (out_valid_q && coef_ready_in && out_last_q) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, symbol latch and output register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= WAIT_DC;
            idx_q       <= {IDX_W{1'b0}};
            pend_q      <= 5'd0;
            then_val_q  <= 1'b0;
            val_q       <= {COEF_W{1'b0}};
            run_q       <= 1'b0;
            out_val_q   <= {COEF_W{1'b0}};
            out_idx_q   <= {IDX_W{1'b0}};
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            then_val_q  <= then_val_d;
            val_q       <= val_d;
            run_q       <= 1'b1;
            out_val_q   <= out_val_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sym_ready_out   = ready_s;
    assign coef_value_out  = out_val_q;
    assign coef_index_out  = out_idx_q;
    assign coef_last_out   = out_last_q;
    assign coef_valid_out  = out_valid_q;
    assign err_out         = err_q;
    assign block_count_out = cnt_q;

endmodule

// File: tb/tb_coef_block_sequencer.sv
// Directed scoreboard bench for coef_block_sequencer: expected beats are queued
// as symbols are accepted and checked as the DUT presents them.
module tb_coef_block_sequencer;
    import tinycodec_pkg::*;

    typedef struct packed {
        logic [COEF_W-1:0] v;
        logic [5:0]        i;
        logic              l;
    } beat_t;

    logic                     clk_in;
    logic                     rst_in;
    logic signed [COEF_W-1:0] sym_value_in;
    logic [4:0]               sym_run_in;
    logic                     sym_dc_in;
    logic                     sym_valid_in;
    logic                     sym_ready_out;
    logic signed [COEF_W-1:0] coef_value_out;
    logic [5:0]               coef_index_out;
    logic                     coef_last_out;
    logic                     coef_valid_out;
    logic                     coef_ready_in;
    logic                     err_out;
    logic [CNT_W-1:0]         block_count_out;

    int    checks;
    int    failures;
    bit    tog;
    beat_t exp_q[$];

    coef_block_sequencer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sym_value_in    (sym_value_in),
        .sym_run_in      (sym_run_in),
        .sym_dc_in       (sym_dc_in),
        .sym_valid_in    (sym_valid_in),
        .sym_ready_out   (sym_ready_out),
        .coef_value_out  (coef_value_out),
        .coef_index_out  (coef_index_out),
        .coef_last_out   (coef_last_out),
        .coef_valid_out  (coef_valid_out),
        .coef_ready_in   (coef_ready_in),
        .err_out         (err_out),
        .block_count_out (block_count_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Output monitor: compare presented beat with the scoreboard head.
    always @(negedge clk_in) begin
        beat_t got;
        beat_t expb;
        if (rst_in) begin
            if (coef_valid_out) begin
                got = {coef_value_out, coef_index_out, coef_last_out};
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL beat_unexpected got v=%0d i=%0d l=%0d", $signed(got.v), got.i, got.l);
                end
                if (exp_q.size() > 0) begin
                    expb = exp_q[0];
                    checks++;
                    assert (got === expb) else begin
                        failures++;
                        $error("FAIL beat got v=%0d i=%0d l=%0d exp v=%0d i=%0d l=%0d",
                               $signed(got.v), got.i, got.l, $signed(expb.v), expb.i, expb.l);
                    end
                    if (coef_ready_in) void'(exp_q.pop_front());
                end
            end
            checks++;
            assert (!(exp_q.size() >= 2 && sym_ready_out)) else begin
                failures++;
                $error("FAIL ready_while_pending got=%0d exp=0 pending=%0d", sym_ready_out, exp_q.size());
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    task automatic push(input int v, input int i);
        beat_t b;
        b.v = COEF_W'(v);
        b.i = 6'(i);
        b.l = (i == 63);
        exp_q.push_back(b);
    endtask

    task automatic push_zeros(input int from, input int to);
        for (int k = from; k <= to; k++) push(0, k);
    endtask

    task automatic send(input int v, input int r, input bit dc);
        bit ok;
        ok           = 1'b0;
        sym_value_in = COEF_W'(v);
        sym_run_in   = 5'(r);
        sym_dc_in    = dc;
        sym_valid_in = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk_in);
            if (sym_ready_out) ok = 1'b1;
            @(posedge clk_in);
            #1;
            if (tog) coef_ready_in = ~coef_ready_in;
            if (ok) break;
        end
        sym_valid_in = 1'b0;
        checks++;
        assert (ok) else begin
            failures++;
            $error("FAIL send_timeout got=0 exp=1 v=%0d r=%0d", v, r);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk_in);
            #1;
            if (tog) coef_ready_in = ~coef_ready_in;
            if (exp_q.size() == 0 && !coef_valid_out) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL drain_timeout got pending=%0d exp=0", exp_q.size());
        end
        coef_ready_in = 1'b1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        tog           = 1'b0;
        rst_in        = 1'b0;
        sym_value_in  = {COEF_W{1'b0}};
        sym_run_in    = 5'd0;
        sym_dc_in     = 1'b0;
        sym_valid_in  = 1'b0;
        coef_ready_in = 1'b1;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid", coef_valid_out, 0);
        chk("rst_value", coef_value_out, 0);
        chk("rst_index", coef_index_out, 0);
        chk("rst_last", coef_last_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_count", block_count_out, 0);
        chk("rst_ready", sym_ready_out, 0);
        rst_in = 1'b1;

        // DC then EOB: 64 beats
        send(37, 0, 1'b1); push(37, 0);
        send(0, 0, 1'b0);  push_zeros(1, 63);
        drain();
        chk("t1_count", block_count_out, 1);
        chk("t1_err", err_out, 0);

        // run 2 then value -3
        send(5, 0, 1'b1);  push(5, 0);
        send(-3, 2, 1'b0); push_zeros(1, 2); push(-3, 3);
        send(0, 0, 1'b0);  push_zeros(4, 63);
        drain();
        chk("t2_count", block_count_out, 2);

        // two ZRLs then run 3
        send(1, 0, 1'b1);  push(1, 0);
        send(0, 15, 1'b0); push_zeros(1, 16);
        send(0, 15, 1'b0); push_zeros(17, 32);
        send(7, 3, 1'b0);  push_zeros(33, 35); push(7, 36);
        send(0, 0, 1'b0);  push_zeros(37, 63);
        drain();
        chk("t3_count", block_count_out, 3);

        // value lands on 63: block completes without EOB
        send(2, 0, 1'b1); push(2, 0);
        for (int k = 1; k <= 63; k++) begin
            send(1, 0, 1'b0);
            push(1, k);
        end
        drain();
        chk("t4_count", block_count_out, 4);
        send(9, 0, 1'b1); push(9, 0);
        send(0, 0, 1'b0); push_zeros(1, 63);
        drain();
        chk("t4_next_count", block_count_out, 5);
        chk("t4_err", err_out, 0);

        // downstream stalls every other cycle during a run-5 expansion
        tog = 1'b1;
        send(4, 0, 1'b1); push(4, 0);
        send(9, 5, 1'b0); push_zeros(1, 5); push(9, 6);
        send(0, 0, 1'b0); push_zeros(7, 63);
        drain();
        tog = 1'b0;
        chk("t5_count", block_count_out, 6);

        // ZRL cut off at 63: not an error
        send(3, 0, 1'b1); push(3, 0);
        for (int z = 0; z < 3; z++) begin
            send(0, 15, 1'b0);
            push_zeros(1 + 16 * z, 16 + 16 * z);
        end
        send(0, 15, 1'b0); push_zeros(49, 63);
        drain();
        chk("t6_zrl_count", block_count_out, 7);
        chk("t6_zrl_err", err_out, 0);

        // run overflows with value dropped: error
        send(6, 0, 1'b1); push(6, 0);
        for (int z = 0; z < 3; z++) begin
            send(0, 15, 1'b0);
            push_zeros(1 + 16 * z, 16 + 16 * z);
        end
        send(5, 20, 1'b0); push_zeros(49, 63);
        drain();
        chk("t6_val_count", block_count_out, 8);
        chk("t6_val_err", err_out, 1);

        rst_in = 1'b0;
        #1;
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst2_err", err_out, 0);
        chk("rst2_count", block_count_out, 0);
        rst_in = 1'b1;

        // AC as first symbol: dropped
        send(4, 3, 1'b0);
        drain();
        chk("t7_err", err_out, 1);
        chk("t7_count", block_count_out, 0);

        // DC mid-block aborts and restarts at index 0
        send(8, 0, 1'b1);  push(8, 0);
        send(2, 1, 1'b0);  push(0, 1); push(2, 2);
        send(11, 0, 1'b1); push(11, 0);
        drain();
        chk("t8_abort_count", block_count_out, 0);
        send(0, 0, 1'b0);  push_zeros(1, 63);
        drain();
        chk("t8_count", block_count_out, 1);

        // async reset in the middle of FILL
        send(1, 0, 1'b1); push(1, 0);
        send(0, 0, 1'b0); push_zeros(1, 63);
        repeat (10) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        chk("t9_valid_async", coef_valid_out, 0);
        chk("t9_ready_async", sym_ready_out, 0);
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        chk("t9_count", block_count_out, 0);
        chk("t9_err", err_out, 0);
        rst_in = 1'b1;

        // maximum legal run after reset
        send(-1, 0, 1'b1); push(-1, 0);
        send(4, 31, 1'b0); push_zeros(1, 31); push(4, 32);
        send(0, 0, 1'b0);  push_zeros(33, 63);
        drain();
        chk("t10_count", block_count_out, 1);
        chk("t10_err", err_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
